// File: rtl/nonrestoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : nonrestoring_divider_if
// Brief    : Start/busy/done handshake and operand/result bundle for the divider.
// Revision : 1.0 - initial release
// ============================================================================
interface nonrestoring_divider_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/nonrestoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : nonrestoring_divider
// Brief    : Unsigned sequential non-restoring divider, 2W-bit / W-bit dividend,
//            one quotient bit per clock, with divide-by-zero and overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module nonrestoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nonrestoring_divider_if.slave bus
);

  localparam int                  c_CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_INIT = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_busy;
  logic                 w_done;

  logic [WIDTH+1:0]     r_a;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_m;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_quotient;
  logic [WIDTH-1:0]     r_remainder;
  logic                 r_div_by_zero;
  logic                 r_overflow;

  logic [WIDTH-1:0]     w_div_hi;
  logic                 w_div_zero;
  logic                 w_div_ovf;
  logic [WIDTH+1:0]     w_m_ext;
  logic [WIDTH+1:0]     w_a_shift;
  logic [WIDTH+1:0]     w_a_iter;
  logic [WIDTH+1:0]     w_a_fix;

  assign w_div_hi   = bus.dividend[2*WIDTH-1:WIDTH];
  assign w_div_zero = (bus.divisor == '0);
  // Quotient fits in WIDTH bits only when the upper half is below the divisor.
  assign w_div_ovf  = (w_div_hi >= bus.divisor);

  assign w_m_ext    = {2'b00, r_m};
  assign w_a_shift  = {r_a[WIDTH:0], r_q[WIDTH-1]};
  assign w_a_iter   = r_a[WIDTH+1] ? (w_a_shift + w_m_ext) : (w_a_shift - w_m_ext);
  assign w_a_fix    = r_a[WIDTH+1] ? (r_a + w_m_ext) : r_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (w_div_zero || w_div_ovf) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ITER;
          end
        end
      end
      S_ITER: begin
        w_busy = 1'b1;
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_busy      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a           <= '0;
      r_q           <= '0;
      r_m           <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_m           <= bus.divisor;
        r_a           <= {2'b00, w_div_hi};
        r_q           <= bus.dividend[WIDTH-1:0];
        r_cnt         <= c_CNT_INIT;
        r_div_by_zero <= 1'b0;
        r_overflow    <= 1'b0;
        if (w_div_zero) begin
          r_div_by_zero <= 1'b1;
          r_quotient    <= '1;
          r_remainder   <= bus.dividend[WIDTH-1:0];
        end else if (w_div_ovf) begin
          r_overflow    <= 1'b1;
          r_quotient    <= '1;
          r_remainder   <= '0;
        end
      end else if (r_state == S_ITER) begin
        r_a   <= w_a_iter;
        r_q   <= {r_q[WIDTH-2:0], ~w_a_iter[WIDTH+1]};
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == S_FIX) begin
        // Results are captured here so they are already stable while done is high.
        r_a         <= w_a_fix;
        r_quotient  <= r_q;
        r_remainder <= w_a_fix[WIDTH-1:0];
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_nonrestoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonrestoring_divider
// Brief    : Scoreboard bench for nonrestoring_divider against a / and % model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonrestoring_divider;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   busy_cnt;

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    bit             dbz;
    bit             ovf;
    int             t_start;
    int             lat;
    int             busy_cycles;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  nonrestoring_divider_if #(.WIDTH(W)) bus ();

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: plain integer division, error cases decided on the full quotient.
  function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b, input int t);
    exp_t e;
    int   ai;
    int   bi;
    ai = int'(a);
    bi = int'(b);
    e.dvd = a;
    e.dvs = b;
    e.t_start = t;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (bi == 0) begin
      e.dbz = 1'b1;
      e.q = '1;
      e.r = a[W-1:0];
      e.lat = 1;
      e.busy_cycles = 0;
    end else if (ai / bi > (1 << W) - 1) begin
      e.ovf = 1'b1;
      e.q = '1;
      e.r = '0;
      e.lat = 1;
      e.busy_cycles = 0;
    end else begin
      e.q = W'(ai / bi);
      e.r = W'(ai % bi);
      e.lat = W + 2;
      e.busy_cycles = W + 1;
    end
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("quotient", bus.quotient, mon_e.q);
          check("remainder", bus.remainder, mon_e.r);
          check("div_by_zero", bus.div_by_zero, mon_e.dbz);
          check("overflow", bus.overflow, mon_e.ovf);
          check("latency", cyc - mon_e.t_start, mon_e.lat);
          check("busy_cycles", busy_cnt, mon_e.busy_cycles);
          if (!mon_e.dbz && !mon_e.ovf) begin
            check("invariant", longint'(bus.quotient) * longint'(mon_e.dvs) + longint'(bus.remainder),
                  longint'(mon_e.dvd));
            check("rem_lt_div", longint'(bus.remainder < mon_e.dvs), 1);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at the falling edge of a cycle in which the divider is idle.
  task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit push);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    if (push) sb.push_back(model(a, b, cyc));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = (2*W)'($urandom);
    bus.divisor  = W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 64; i++) begin
      if (bus.done) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL done_timeout actual=0 required=1 (cycle %0d)", cyc);
  endtask

  task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
    issue(a, b, 1'b1);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    total = 0;
    bad = 0;
    busy_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_flags", {bus.div_by_zero, bus.overflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, including quotient width boundaries.
    run_op(16'd150, 8'd5);
    run_op(16'd1000, 8'd7);
    run_op(16'd1234, 8'd0);
    run_op(16'hFFFF, 8'd255);
    run_op(16'h00FF, 8'd255);
    run_op(16'hFEFF, 8'd255);
    run_op(16'h00FF, 8'd1);
    run_op(16'h0100, 8'd1);
    run_op(16'h0000, 8'd0);
    run_op(16'h0000, 8'd3);

    // Start arriving while busy must be dropped.
    issue(16'd1000, 8'd7, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'd150;
    bus.divisor = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);

    // Start held high retriggers in the idle cycle right after done.
    bus.dividend = 16'd4321;
    bus.divisor = 8'd99;
    bus.start = 1'b1;
    sb.push_back(model(16'd4321, 8'd99, cyc));
    @(negedge clk);
    wait_done();
    sb.push_back(model(16'd4321, 8'd99, cyc + 1));
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset in the middle of an iteration aborts without a done.
    issue(16'd30000, 8'd200, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_flags", {bus.div_by_zero, bus.overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd30000, 8'd200);

    // Random sweep, biased toward in-range quotients.
    for (int n = 0; n < 3000; n++) begin
      b = ($urandom_range(0, 31) == 0) ? W'(0) : W'($urandom_range(1, (1 << W) - 1));
      if ($urandom_range(0, 9) == 0 || b == 0) begin
        a = (2*W)'($urandom);
      end else begin
        a = (2*W)'($urandom_range(0, int'(b) * (1 << W) - 1));
      end
      run_op(a, b);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
